risc_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core. Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath's enables, mux selects and `alu_op_t` encoding from the latched instruction. It also handshakes with the unified memory port. It sits beside the datapath and holds no architectural state (PC, IR and register file live in the datapath).

---
 rtl/risc_ctrl_fsm.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_risc_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc_ctrl_fsm.sv
// risc_ctrl_fsm: multi-cycle RV32I control sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional feature: define RISC_ILLEGAL_TRAP_EN to trap illegal encodings instead of running them as NOP.
package risc_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I_ALU  = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_B_TYPE = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_t;
endpackage

module risc_ctrl_fsm
  import risc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [2:0]  imm_sel,
  output logic [3:0]  alu_op,
  output logic        illegal_instr,
  output logic        bus_error,
  output logic [2:0]  state_dbg
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic          bus_error_q;
  logic          set_bus_error;
  logic          timeout_hit;

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          legal;
  logic          br_taken;
  alu_op_t       dec_alu_op;
  logic [1:0]    dec_src_a;
  logic          dec_src_b;
  logic [2:0]    dec_imm;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register indices and immediates are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  // NOTE: every variable written in an always_comb gets a default first; a
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    legal      = 1'b1;
    dec_alu_op = ALU_ADD;
    dec_src_a  = 2'd0;
    dec_src_b  = 1'b0;
    dec_imm    = 3'd0;
    case (opcode)
      OP_R, OP_I_ALU: begin
        dec_src_b = (opcode == OP_I_ALU);
        case (funct3)
          3'b000:  dec_alu_op = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_alu_op = ALU_SLL;
          3'b010:  dec_alu_op = ALU_SLT;
          3'b011:  dec_alu_op = ALU_SLTU;
          3'b100:  dec_alu_op = ALU_XOR;
          3'b101:  dec_alu_op = instr[30] ? ALU_SRA : ALU_SRL;
          3'b110:  dec_alu_op = ALU_OR;
          default: dec_alu_op = ALU_AND;
        endcase
        if (opcode == OP_R && funct7 != 7'h00 && funct7 != 7'h20) legal = 1'b0;
      end
      OP_LOAD, OP_JALR: dec_src_b = 1'b1;
      OP_STORE: begin
        dec_src_b = 1'b1;
        dec_imm   = 3'd1;
      end
      OP_B_TYPE: begin
        dec_alu_op = ALU_SUB;
        dec_imm    = 3'd2;
      end
      OP_LUI: begin
        dec_src_a = 2'd2;
        dec_src_b = 1'b1;
        dec_imm   = 3'd3;
      end
      OP_AUIPC: begin
        dec_src_a = 2'd1;
        dec_src_b = 1'b1;
        dec_imm   = 3'd3;
      end
      OP_JAL: begin
        dec_src_a = 2'd1;
        dec_src_b = 1'b1;
        dec_imm   = 3'd4;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Fires on the last permitted wait cycle so the trap lands exactly MEM_TIMEOUT cycles in.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                       (wait_cnt == CW'(MEM_TIMEOUT - 1));

`ifdef RISC_ILLEGAL_TRAP_EN
  logic set_illegal;
`endif

  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_is_fetch  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 2'd0;
    rf_we         = 1'b0;
    wb_sel        = 2'd0;
    alu_src_a     = 2'd0;
    alu_src_b     = 1'b0;
    imm_sel       = 3'd0;
    alu_op        = ALU_ADD;
    set_bus_error = 1'b0;
`ifdef RISC_ILLEGAL_TRAP_EN
    set_illegal   = 1'b0;
`endif
    // Outputs are gated by rst_n so no enable leaks out during a reset cycle.
    if (rst_n) begin
      if (state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
        alu_op    = dec_alu_op;
        alu_src_a = dec_src_a;
        alu_src_b = dec_src_b;
        imm_sel   = dec_imm;
      end
      case (state)
        ST_IDLE: next_state = ST_FETCH;
        ST_FETCH: begin
          mem_req      = 1'b1;
          mem_is_fetch = 1'b1;
          if (mem_ready) begin
            ir_we      = 1'b1;
            next_state = ST_DECODE;
          end else if (timeout_hit) begin
            set_bus_error = 1'b1;
            next_state    = ST_TRAP;
          end
        end
        ST_DECODE: begin
`ifdef RISC_ILLEGAL_TRAP_EN
          if (!legal) begin
            set_illegal = 1'b1;
            next_state  = ST_TRAP;
          end else begin
            next_state = ST_EXEC;
          end
`else
          next_state = ST_EXEC;
`endif
        end
        ST_EXEC: begin
          if (!legal) begin
            pc_we      = 1'b1;
            next_state = ST_FETCH;
          end else begin
            case (opcode)
              OP_LOAD, OP_STORE: next_state = ST_MEM;
              OP_B_TYPE: begin
                pc_we      = 1'b1;
                pc_sel     = br_taken ? 2'd1 : 2'd0;
                next_state = ST_FETCH;
              end
              default: next_state = ST_WB;
            endcase
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (opcode == OP_STORE);
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              pc_we      = 1'b1;
              next_state = ST_FETCH;
            end else begin
              next_state = ST_WB;
            end
          end else if (timeout_hit) begin
            set_bus_error = 1'b1;
            next_state    = ST_TRAP;
          end
        end
        ST_WB: begin
          rf_we      = 1'b1;
          pc_we      = 1'b1;
          next_state = ST_FETCH;
          case (opcode)
            OP_JAL: begin
              wb_sel = 2'd2;
              pc_sel = 2'd1;
            end
            OP_JALR: begin
              wb_sel = 2'd2;
              pc_sel = 2'd2;
            end
            OP_LOAD: wb_sel = 2'd1;
            default: wb_sel = 2'd0;
          endcase
        end
        ST_TRAP: next_state = ST_TRAP;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // branch is inside the clocked block because reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bus_error_q <= 1'b0;
    end else begin
      state <= next_state;
      if (set_bus_error) bus_error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (next_state != state) begin
      wait_cnt <= '0;
    end else if ((state == ST_FETCH || state == ST_MEM) && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef RISC_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_q <= 1'b0;
    else if (set_illegal) illegal_q <= 1'b1;
  end
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  assign bus_error = bus_error_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Directed testbench for risc_ctrl_fsm (MEM_TIMEOUT=4); honours RISC_ILLEGAL_TRAP_EN when defined.
module tb_risc_ctrl_fsm;
  import risc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        br_eq, br_lt, br_ltu, mem_ready;
  logic        mem_req, mem_we, mem_is_fetch, ir_we, pc_we, rf_we, alu_src_b;
  logic [1:0]  pc_sel, wb_sel, alu_src_a;
  logic [2:0]  imm_sel, state_dbg;
  logic [3:0]  alu_op;
  logic        illegal_instr, bus_error;

  int checks = 0;
  int errors = 0;

  risc_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_sel(imm_sel), .alu_op(alu_op),
    .illegal_instr(illegal_instr), .bus_error(bus_error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr = 32'h002081B3; mem_ready = 1'b1;
    br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
    tick(); tick();
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    checks++; if ({mem_req, mem_we, mem_is_fetch, ir_we, pc_we, rf_we} !== 6'b0) begin errors++; $display("FAIL reset_enables: got %b expected 000000", {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, rf_we}); end
    checks++; if ({pc_sel, wb_sel, alu_src_a, alu_src_b, imm_sel} !== 10'b0) begin errors++; $display("FAIL reset_selects: got %b expected 0", {pc_sel, wb_sel, alu_src_a, alu_src_b, imm_sel}); end
    checks++; if (alu_op !== ALU_ADD) begin errors++; $display("FAIL reset_alu_op: got %0d expected %0d", alu_op, ALU_ADD); end
    checks++; if ({bus_error, illegal_instr} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {bus_error, illegal_instr}); end
    rst_n = 1'b1;
    #1;
    checks++; if (state_dbg !== 3'd0 || mem_req !== 1'b0) begin errors++; $display("FAIL release_idle: state %0d req %b expected 0 0", state_dbg, mem_req); end
    tick();
    checks++; if (state_dbg !== 3'd1 || mem_req !== 1'b1 || mem_is_fetch !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL first_fetch: state %0d req %b fetch %b we %b expected 1 1 1 0", state_dbg, mem_req, mem_is_fetch, mem_we); end
    checks++; if (ir_we !== 1'b1) begin errors++; $display("FAIL fetch_ir_we: got %b expected 1", ir_we); end
  endtask

  task automatic test_alu_add();
    tick();
    checks++; if (state_dbg !== 3'd2 || ir_we !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL add_decode: state %0d ir_we %b req %b expected 2 0 0", state_dbg, ir_we, mem_req); end
    tick();
    checks++; if (state_dbg !== 3'd3 || alu_op !== ALU_ADD || rf_we !== 1'b0 || pc_we !== 1'b0) begin errors++; $display("FAIL add_exec: state %0d op %0d rf %b pc %b expected 3 %0d 0 0", state_dbg, alu_op, rf_we, pc_we, ALU_ADD); end
    tick();
    checks++; if (state_dbg !== 3'd5 || rf_we !== 1'b1 || pc_we !== 1'b1 || wb_sel !== 2'd0 || pc_sel !== 2'd0) begin errors++; $display("FAIL add_wb: state %0d rf %b pc %b wb %0d psel %0d expected 5 1 1 0 0", state_dbg, rf_we, pc_we, wb_sel, pc_sel); end
    tick();
    checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL add_refetch: got state %0d expected 1", state_dbg); end
  endtask

  task automatic test_alu_decode();
    logic [31:0] vi [4] = '{32'h40208233, 32'h4020D213, 32'h40008093, 32'h0020C1B3};
    logic [3:0]  vo [4] = '{ALU_SUB, ALU_SRA, ALU_ADD, ALU_XOR};
    logic        vb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      instr = vi[i];
      tick(); tick();
      checks++; if (state_dbg !== 3'd3 || alu_op !== vo[i] || alu_src_b !== vb[i]) begin errors++; $display("FAIL decode_%0h: state %0d op %0d srcb %b expected 3 %0d %b", vi[i], state_dbg, alu_op, alu_src_b, vo[i], vb[i]); end
      tick(); tick();
      checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL decode_return_%0h: got state %0d expected 1", vi[i], state_dbg); end
    end
  endtask

  task automatic test_jump_upper();
    // JAL, JALR, LUI, AUIPC
    logic [31:0] vi [4] = '{32'h008000EF, 32'h000080E7, 32'h000011B7, 32'h00001197};
    logic [1:0]  va [4] = '{2'd1, 2'd0, 2'd2, 2'd1};
    logic [2:0]  vm [4] = '{3'd4, 3'd0, 3'd3, 3'd3};
    logic [1:0]  vw [4] = '{2'd2, 2'd2, 2'd0, 2'd0};
    logic [1:0]  vp [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      instr = vi[i];
      tick(); tick();
      checks++; if (alu_src_a !== va[i] || imm_sel !== vm[i] || alu_src_b !== 1'b1 || alu_op !== ALU_ADD) begin errors++; $display("FAIL jump_exec_%0h: srca %0d imm %0d srcb %b op %0d expected %0d %0d 1 %0d", vi[i], alu_src_a, imm_sel, alu_src_b, alu_op, va[i], vm[i], ALU_ADD); end
      tick();
      checks++; if (state_dbg !== 3'd5 || wb_sel !== vw[i] || pc_sel !== vp[i] || rf_we !== 1'b1) begin errors++; $display("FAIL jump_wb_%0h: state %0d wb %0d psel %0d rf %b expected 5 %0d %0d 1", vi[i], state_dbg, wb_sel, pc_sel, rf_we, vw[i], vp[i]); end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [31:0] vi [5] = '{32'h00209463, 32'h00209463, 32'h0020A463, 32'h0020C463, 32'h0020F463};
    logic [2:0]  vf [5] = '{3'b000, 3'b100, 3'b011, 3'b010, 3'b000};
    logic [1:0]  vs [5] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
    for (int i = 0; i < 5; i++) begin
      instr = vi[i];
      {br_eq, br_lt, br_ltu} = vf[i];
      tick();
      checks++; if (imm_sel !== 3'd2) begin errors++; $display("FAIL branch_imm_%0d: got %0d expected 2", i, imm_sel); end
      tick();
      checks++; if (state_dbg !== 3'd3 || pc_we !== 1'b1 || pc_sel !== vs[i] || alu_op !== ALU_SUB) begin errors++; $display("FAIL branch_exec_%0d: state %0d pc_we %b psel %0d op %0d expected 3 1 %0d %0d", i, state_dbg, pc_we, pc_sel, alu_op, vs[i], ALU_SUB); end
      tick();
      checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL branch_return_%0d: got state %0d expected 1", i, state_dbg); end
    end
    {br_eq, br_lt, br_ltu} = 3'b000;
  endtask

  task automatic test_load_wait();
    instr = 32'h0000A183;
    tick(); tick();
    checks++; if (state_dbg !== 3'd3 || alu_src_b !== 1'b1 || alu_op !== ALU_ADD) begin errors++; $display("FAIL load_exec: state %0d srcb %b op %0d expected 3 1 %0d", state_dbg, alu_src_b, alu_op, ALU_ADD); end
    mem_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (state_dbg !== 3'd4 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_is_fetch !== 1'b0 || pc_we !== 1'b0) begin errors++; $display("FAIL load_wait_%0d: state %0d req %b we %b fetch %b pc %b expected 4 1 0 0 0", c, state_dbg, mem_req, mem_we, mem_is_fetch, pc_we); end
    end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++; if (state_dbg !== 3'd4 || mem_req !== 1'b1 || bus_error !== 1'b0) begin errors++; $display("FAIL load_ready_at_limit: state %0d req %b buserr %b expected 4 1 0", state_dbg, mem_req, bus_error); end
    tick();
    checks++; if (state_dbg !== 3'd5 || wb_sel !== 2'd1 || rf_we !== 1'b1 || pc_sel !== 2'd0 || bus_error !== 1'b0) begin errors++; $display("FAIL load_wb: state %0d wb %0d rf %b psel %0d buserr %b expected 5 1 1 0 0", state_dbg, wb_sel, rf_we, pc_sel, bus_error); end
    tick();
    checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL load_return: got state %0d expected 1", state_dbg); end
  endtask

  task automatic test_store();
    instr = 32'h0020A023;
    tick(); tick();
    checks++; if (imm_sel !== 3'd1 || alu_src_b !== 1'b1) begin errors++; $display("FAIL store_exec: imm %0d srcb %b expected 1 1", imm_sel, alu_src_b); end
    mem_ready = 1'b0;
    tick();
    checks++; if (state_dbg !== 3'd4 || mem_we !== 1'b1 || mem_req !== 1'b1 || pc_we !== 1'b0) begin errors++; $display("FAIL store_wait: state %0d we %b req %b pc %b expected 4 1 1 0", state_dbg, mem_we, mem_req, pc_we); end
    mem_ready = 1'b1;
    #1;
    checks++; if (pc_we !== 1'b1 || pc_sel !== 2'd0 || rf_we !== 1'b0) begin errors++; $display("FAIL store_ready: pc %b psel %0d rf %b expected 1 0 0", pc_we, pc_sel, rf_we); end
    tick();
    checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL store_return: got state %0d expected 1", state_dbg); end
  endtask

  task automatic test_fetch_wait();
    instr = 32'h002081B3;
    mem_ready = 1'b0;
    #1;
    checks++; if (ir_we !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL fetch_wait: ir_we %b req %b expected 0 1", ir_we, mem_req); end
    tick(); tick(); tick();
    mem_ready = 1'b1;
    #1;
    checks++; if (ir_we !== 1'b1 || bus_error !== 1'b0 || state_dbg !== 3'd1) begin errors++; $display("FAIL fetch_ready_at_limit: ir_we %b buserr %b state %0d expected 1 0 1", ir_we, bus_error, state_dbg); end
    tick();
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL fetch_wait_decode: got state %0d expected 2", state_dbg); end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    instr = 32'h002081B3;
    tick(); tick(); tick();
    checks++; if (state_dbg !== 3'd5 || rf_we !== 1'b1) begin errors++; $display("FAIL mid_wb: state %0d rf %b expected 5 1", state_dbg, rf_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || pc_we !== 1'b0) begin errors++; $display("FAIL mid_reset_enables: rf %b pc %b expected 0 0", rf_we, pc_we); end
    tick();
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL mid_reset_idle: got state %0d expected 0", state_dbg); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    instr = 32'hFFFFFFFF;
    tick();
    checks++; if (state_dbg !== 3'd2 || illegal_instr !== 1'b0) begin errors++; $display("FAIL illegal_decode: state %0d ill %b expected 2 0", state_dbg, illegal_instr); end
    tick();
`ifdef RISC_ILLEGAL_TRAP_EN
    checks++; if (state_dbg !== 3'd6 || illegal_instr !== 1'b1 || mem_req !== 1'b0 || pc_we !== 1'b0) begin errors++; $display("FAIL illegal_trap: state %0d ill %b req %b pc %b expected 6 1 0 0", state_dbg, illegal_instr, mem_req, pc_we); end
    tick();
    checks++; if (state_dbg !== 3'd6 || illegal_instr !== 1'b1) begin errors++; $display("FAIL illegal_hold: state %0d ill %b expected 6 1", state_dbg, illegal_instr); end
    rst_n = 1'b0;
    tick();
    checks++; if (state_dbg !== 3'd0 || illegal_instr !== 1'b0) begin errors++; $display("FAIL illegal_clear: state %0d ill %b expected 0 0", state_dbg, illegal_instr); end
    rst_n = 1'b1;
    tick();
`else
    checks++; if (state_dbg !== 3'd3 || pc_we !== 1'b1 || pc_sel !== 2'd0 || rf_we !== 1'b0 || illegal_instr !== 1'b0) begin errors++; $display("FAIL illegal_nop: state %0d pc %b psel %0d rf %b ill %b expected 3 1 0 0 0", state_dbg, pc_we, pc_sel, rf_we, illegal_instr); end
    tick();
`endif
    checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL illegal_return: got state %0d expected 1", state_dbg); end
  endtask

  task automatic test_timeout();
    instr = 32'h002081B3;
    mem_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (state_dbg !== 3'd1 || bus_error !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL timeout_before: state %0d buserr %b req %b expected 1 0 1", state_dbg, bus_error, mem_req); end
    tick();
    checks++; if (state_dbg !== 3'd6 || bus_error !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_trap: state %0d buserr %b req %b expected 6 1 0", state_dbg, bus_error, mem_req); end
    mem_ready = 1'b1;
    tick();
    checks++; if (state_dbg !== 3'd6 || bus_error !== 1'b1 || mem_req !== 1'b0 || ir_we !== 1'b0) begin errors++; $display("FAIL timeout_hold: state %0d buserr %b req %b ir %b expected 6 1 0 0", state_dbg, bus_error, mem_req, ir_we); end
    rst_n = 1'b0;
    tick();
    checks++; if (state_dbg !== 3'd0 || bus_error !== 1'b0) begin errors++; $display("FAIL timeout_clear: state %0d buserr %b expected 0 0", state_dbg, bus_error); end
    rst_n = 1'b1;
    tick();
    checks++; if (state_dbg !== 3'd1 || mem_req !== 1'b1) begin errors++; $display("FAIL timeout_restart: state %0d req %b expected 1 1", state_dbg, mem_req); end
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_alu_decode();
    test_jump_upper();
    test_branch();
    test_load_wait();
    test_store();
    test_fetch_wait();
    test_reset_mid();
    test_illegal();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
